// File: rtl/block_accumulator_if.sv
// Sample-in / result-out handshake bundle for block_accumulator.
// slave is the accumulator's view; master is the source/consumer view.
interface block_accumulator_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/block_accumulator.sv
// Streaming 64-bit block accumulator built around one shared 32-bit adder,
// two passes per sample (low word, then high word with the held carry).

module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  logic [32:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[32];
endmodule

module block_accumulator #(
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rstn,
  block_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADD_LO, ADD_HI, DONE} state_t;

  state_t           state, state_next;
  logic [31:0]      acc_lo, acc_hi;
  logic             carry;
  logic [63:0]      data_reg;
  logic             last_reg;
  logic [CNT_W-1:0] count;
  logic             ovf;

  logic [31:0]      add_a, add_b, add_s;
  logic             add_cin, add_cout;

  adder32 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  // The high pass reuses the adder with the carry saved from the low pass.
  always_comb begin
    add_a   = acc_lo;
    add_b   = data_reg[31:0];
    add_cin = 1'b0;
    if (state == ADD_HI) begin
      add_a   = acc_hi;
      add_b   = data_reg[63:32];
      add_cin = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = ADD_LO;
      ADD_LO:  state_next = ADD_HI;
      ADD_HI:  state_next = last_reg ? DONE : IDLE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_lo   <= '0;
      acc_hi   <= '0;
      carry    <= 1'b0;
      data_reg <= '0;
      last_reg <= 1'b0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_reg <= bus.in_data;
            last_reg <= bus.in_last;
          end
        end
        ADD_LO: begin
          acc_lo <= add_s;
          carry  <= add_cout;
        end
        ADD_HI: begin
          acc_hi <= add_s;
          ovf    <= ovf | add_cout;
          if (count != '1) count <= count + CNT_W'(1);
        end
        DONE: begin
          if (bus.out_ready) begin
            acc_lo <= '0;
            acc_hi <= '0;
            carry  <= 1'b0;
            count  <= '0;
            ovf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = {acc_hi, acc_lo};
  assign bus.out_count = count;
  assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_block_accumulator.sv
// Directed self-checking bench for block_accumulator; inputs change and
// outputs are sampled on the falling edge.
module tb_block_accumulator;
  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_fail   = 0;

  block_accumulator_if #(.CNT_W(16)) bus ();

  block_accumulator #(.CNT_W(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_clear(input string tag);
    check({tag, ".in_ready"},  64'(bus.in_ready),  64'd1);
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, ".out_sum"},   bus.out_sum,        64'd0);
    check({tag, ".out_count"}, 64'(bus.out_count), 64'd0);
    check({tag, ".out_ovf"},   64'(bus.out_ovf),   64'd0);
  endtask

  // Waits (bounded) for in_ready, then presents one sample for exactly one
  // accepting edge; returns on the falling edge after the accept.
  task automatic send(input logic [63:0] data, input logic last);
    int k = 0;
    while (!bus.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("send_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 64'hDEAD_BEEF_0BAD_F00D;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!bus.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("wait_out_valid", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_idle_clear("after_take");
  endtask

  initial begin
    rstn          = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'hA5A5_5A5A_1234_5678;
    bus.in_last   = 1'b1;
    bus.out_ready = 1'b0;

    // Reset with garbage offered on the input
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_clear("reset");
    bus.in_valid = 1'b0;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_clear("post_reset");

    // Single sample, latency check
    send(64'd5, 1'b1);
    check("single.E0.in_ready", 64'(bus.in_ready), 64'd0);
    check("single.E0.out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("single.E1.out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("single.E2.out_valid", 64'(bus.out_valid), 64'd1);
    check("single.sum",   bus.out_sum,        64'd5);
    check("single.count", 64'(bus.out_count), 64'd1);
    check("single.ovf",   64'(bus.out_ovf),   64'd0);
    take_result();

    // Carry across the 32-bit boundary
    send(64'h0000_0000_FFFF_FFFF, 1'b0);
    send(64'h1, 1'b1);
    wait_valid();
    check("carry.sum",   bus.out_sum,        64'h0000_0001_0000_0000);
    check("carry.count", 64'(bus.out_count), 64'd2);
    check("carry.ovf",   64'(bus.out_ovf),   64'd0);
    take_result();

    // 64-bit wrap
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'h2, 1'b1);
    wait_valid();
    check("ovf.sum",   bus.out_sum,        64'h1);
    check("ovf.count", 64'(bus.out_count), 64'd2);
    check("ovf.ovf",   64'(bus.out_ovf),   64'd1);

    // Backpressure on the wrapped result while a new sample is offered
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h99;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.out_valid", 64'(bus.out_valid), 64'd1);
      check("bp.in_ready",  64'(bus.in_ready),  64'd0);
      check("bp.sum",       bus.out_sum,        64'h1);
      check("bp.count",     64'(bus.out_count), 64'd2);
      check("bp.ovf",       64'(bus.out_ovf),   64'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_idle_clear("bp_release");
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp.next_accepted", 64'(bus.in_ready), 64'd0);
    wait_valid();
    check("bp.next_sum",   bus.out_sum,        64'h99);
    check("bp.next_count", 64'(bus.out_count), 64'd1);
    check("bp.next_ovf",   64'(bus.out_ovf),   64'd0);
    take_result();

    // Three-sample block with out_ready held high: DONE lasts one cycle
    bus.out_ready = 1'b1;
    send(64'd1, 1'b0);
    send(64'd2, 1'b0);
    send(64'h1_0000_0003, 1'b1);
    wait_valid();
    check("three.sum",   bus.out_sum,        64'h1_0000_0006);
    check("three.count", 64'(bus.out_count), 64'd3);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_idle_clear("three_done_1cyc");

    // Reset at the edge that ends ADD_HI
    send(64'd7, 1'b1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_idle_clear("midreset");
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midreset.no_valid", 64'(bus.out_valid), 64'd0);
    end
    send(64'd3, 1'b1);
    wait_valid();
    check("after_reset.sum",   bus.out_sum,        64'd3);
    check("after_reset.count", 64'(bus.out_count), 64'd1);
    check("after_reset.ovf",   64'(bus.out_ovf),   64'd0);
    take_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/block_accumulator.md
# block_accumulator

Streaming 64-bit accumulator that sums a block of unsigned 64-bit samples and emits the total, sample count and overflow flag. It sits downstream of the 32-bit ripple-carry adder datapath and is its consumer: one shared 32-bit adder with carry-in and carry-out computes each 64-bit sum in two passes, low word then high word, with the carry held in a register between them. Samples arrive over a valid/ready handshake, and the block result leaves over a second valid/ready handshake.

## Interface
- CNT_W, 16: width of the sample counter and of out_count.

- clk  in  1  rising-edge clock; the only clock.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_data and in_last are valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  64  unsigned sample.
- in_last  in  1  the sample is the final one of its block.
- out_valid  out  1  result is presented.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  64  block sum, modulo 2^64.
- out_count  out  CNT_W  samples in the block, saturating.
- out_ovf  out  1  sticky: the 64-bit sum wrapped at least once in the block.

## Operation
- Datapath:
  - one 32-bit adder instance with ports a, b, cin, s, cout.
  - Registers: acc_lo[31:0], acc_hi[31:0], carry, data_reg[63:0], last_reg, count[CNT_W-1:0], ovf.
- FSM states: IDLE, ADD_LO, ADD_HI, DONE.
  - IDLE: in_ready=1. On in_valid, capture in_data into data_reg and in_last into last_reg, then go to ADD_LO.
  - ADD_LO: adder a=acc_lo, b=data_reg[31:0], cin=0. Write acc_lo<=s and carry<=cout. Go to ADD_HI.
  - ADD_HI: adder a=acc_hi, b=data_reg[63:32], cin=carry.
    - Write acc_hi<=s and ovf<=ovf|cout.
    - count<=count+1, holding at 2^CNT_W-1.
    - Go to DONE if last_reg, else IDLE.
  - DONE: out_valid=1. On out_ready, clear acc_lo, acc_hi, carry, count and ovf, then go to IDLE.
- in_ready=1 only in IDLE. out_valid=1 only in DONE. Both are pure decodes of the state register.
- out_sum={acc_hi,acc_lo}, out_count=count, out_ovf=ovf, driven directly from registers.
  - These are stable for as long as out_valid is high.
  - Outside DONE they show partial values; the consumer ignores them.
- Arithmetic is unsigned; the sum wraps modulo 2^64. The count saturates and never wraps.
- in_valid while in_ready=0 has no effect; the source must hold its sample.
- out_ready while out_valid=0 has no effect.
- Reset (rstn=0 at a rising edge):
  - state=IDLE; acc_lo, acc_hi, carry, data_reg, last_reg, count and ovf all 0.
  - Outputs after reset: in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - Reset takes priority in every state. A partial sum or pending result is discarded, and no out_valid pulse follows.

## Timing
- Sample accepted at edge E0, when in_valid and in_ready are both high.
  - acc_lo is updated at E1 and acc_hi at E2.
  - If the sample is not last, in_ready is high again after E2, so the next accept is at E3 at the earliest.
- Maximum throughput is one sample per 3 cycles.
- Last sample accepted at E0: out_valid is high after E2. This is a latency of 2 cycles from accept to result.
- Result transfer happens at the edge where out_valid and out_ready are both high.
  - out_valid is low after that edge, and in_ready is high, with the accumulator cleared.
  - The next sample can be accepted 1 edge later.
- out_ready may be held high permanently. DONE then lasts exactly 1 cycle.
- A block of N samples completes in 3N cycles plus the output handshake.

## Test plan
- Reset: drive rstn=0 for 2 cycles with in_valid=1 and garbage on in_data.
  - Required: in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - Required: no sample is accepted while rstn=0.
- Single sample: in_data=5 with in_last=1, accepted at E0.
  - Required: out_valid rises after E2 with out_sum=5, out_count=1, out_ovf=0.
- Carry across the 32-bit boundary: samples 0x0000_0000_FFFF_FFFF then 0x1 (last).
  - Required: out_sum=0x0000_0001_0000_0000, out_count=2, out_ovf=0.
- 64-bit overflow: samples 0xFFFF_FFFF_FFFF_FFFF then 0x2 (last).
  - Required: out_sum=0x1, out_count=2, out_ovf=1.
- Backpressure: after a block result is presented, hold out_ready=0 for 5 cycles with in_valid=1.
  - Required: out_valid stays 1 with outputs unchanged, and in_ready stays 0.
  - Then set out_ready=1. Required: the next cycle has out_valid=0 and in_ready=1, and the next block starts from sum 0.
- Reset mid-operation: start sample 7 (last), then drive rstn=0 at the edge that ends ADD_HI.
  - Required: no out_valid, all outputs 0, in_ready=1.
  - A following block with sample 3 (last) yields out_sum=3, out_count=1.
